// File: rtl/note_sequencer.sv
// Programmable melody source: loads a (pitch, duration) note table over a
// valid/ready port and plays it at the fs tick rate, driving the tone
// generator's pitch divider and per-note restart strobe.
module note_sequencer #(
  parameter int unsigned PITCH_BITWIDTH = 9,
  parameter int unsigned DUR_BITWIDTH   = 13,
  parameter int unsigned DEPTH_LOG2     = 5,
  parameter int unsigned FS_BITWIDTH    = 11,
  parameter int unsigned FS_MAXVAL      = 1250
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [PITCH_BITWIDTH-1:0] load_pitch_i,
  input  logic [DUR_BITWIDTH-1:0]   load_duration_i,
  input  logic                      load_last_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      loop_en_i,
  output logic [PITCH_BITWIDTH-1:0] pitch_o,
  output logic                      rest_o,
  output logic                      note_start_o,
  output logic                      playing_o,
  output logic                      done_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LEN_W = DEPTH_LOG2 + 1;
  localparam logic [FS_BITWIDTH-1:0] FS_LAST  = FS_BITWIDTH'(FS_MAXVAL - 1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_LAST = DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e                     state_q, state_d;
  logic [DEPTH_LOG2-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [DEPTH_LOG2-1:0]      idx_q, idx_d;
  logic [FS_BITWIDTH-1:0]     fs_q, fs_d;
  logic [DUR_BITWIDTH-1:0]    dur_q, dur_d;
  logic [PITCH_BITWIDTH-1:0]  pitch_q, pitch_d;
  logic                       rest_q, rest_d;
  logic                       note_start_q, note_start_d;
  logic                       playing_q, playing_d;
  logic                       done_q, done_d;
  logic                       load_ready_q, load_ready_d;

  logic [PITCH_BITWIDTH-1:0]  mem_pitch_q [DEPTH];
  logic [DUR_BITWIDTH-1:0]    mem_dur_q   [DEPTH];

  logic                       wr_en;
  logic                       enter;
  logic [DEPTH_LOG2-1:0]      enter_idx;
  logic [PITCH_BITWIDTH-1:0]  enter_pitch;
  logic [DUR_BITWIDTH-1:0]    cur_dur;
  logic [DUR_BITWIDTH-1:0]    dur_last;
  logic                       tick;
  logic                       note_end;
  logic                       idx_is_last;

  // A zero duration plays as one tick, so the last tick index saturates at 0.
  assign cur_dur     = mem_dur_q[idx_q];
  assign dur_last    = (cur_dur == '0) ? '0 : cur_dur - DUR_BITWIDTH'(1);
  assign tick        = (fs_q == FS_LAST);
  assign note_end    = tick && (dur_q == dur_last);
  assign idx_is_last = ({1'b0, idx_q} == len_q - LEN_W'(1));

  // Table storage; contents survive reset, only len marks validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_pitch_q[wr_ptr_q] <= load_pitch_i;
      mem_dur_q[wr_ptr_q]   <= load_duration_i;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      fs_q         <= '0;
      dur_q        <= '0;
      pitch_q      <= '0;
      rest_q       <= 1'b1;
      note_start_q <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      fs_q         <= fs_d;
      dur_q        <= dur_d;
      pitch_q      <= pitch_d;
      rest_q       <= rest_d;
      note_start_q <= note_start_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Next-state: table loading in IDLE, note sequencing in PLAY.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    len_d        = len_q;
    idx_d        = idx_q;
    fs_d         = fs_q;
    dur_d        = dur_q;
    pitch_d      = pitch_q;
    rest_d       = rest_q;
    note_start_d = 1'b0;
    playing_d    = playing_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    enter        = 1'b0;
    enter_idx    = '0;
    enter_pitch  = '0;

    unique case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          wr_en = 1'b1;
          if (load_last_i || (wr_ptr_q == PTR_LAST)) begin
            len_d    = LEN_W'(wr_ptr_q) + LEN_W'(1);
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          end
        end
        if (start_i && !stop_i && (len_q != '0)) begin
          state_d   = PLAY;
          enter     = 1'b1;
          enter_idx = '0;
        end
      end
      PLAY: begin
        if (stop_i) begin
          state_d   = IDLE;
          playing_d = 1'b0;
          pitch_d   = '0;
          rest_d    = 1'b1;
        end else if (note_end) begin
          if (!idx_is_last) begin
            enter     = 1'b1;
            enter_idx = idx_q + DEPTH_LOG2'(1);
          end else if (loop_en_i) begin
            enter     = 1'b1;
            enter_idx = '0;
          end else begin
            state_d   = IDLE;
            playing_d = 1'b0;
            pitch_d   = '0;
            rest_d    = 1'b1;
            done_d    = 1'b1;
          end
        end else if (tick) begin
          fs_d  = '0;
          dur_d = dur_q + DUR_BITWIDTH'(1);
        end else begin
          fs_d = fs_q + FS_BITWIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Common entry into a note: restart counters and present its pitch.
    if (enter) begin
      enter_pitch  = mem_pitch_q[enter_idx];
      idx_d        = enter_idx;
      fs_d         = '0;
      dur_d        = '0;
      note_start_d = 1'b1;
      playing_d    = 1'b1;
      pitch_d      = enter_pitch;
      rest_d       = (enter_pitch == '0);
    end

    load_ready_d = (state_d == IDLE);
  end

  assign pitch_o      = pitch_q;
  assign rest_o       = rest_q;
  assign note_start_o = note_start_q;
  assign playing_o    = playing_q;
  assign done_o       = done_q;
  assign load_ready_o = load_ready_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a timeline-based melody model.
module tb_note_sequencer;

  localparam int unsigned PW    = 9;
  localparam int unsigned DW    = 13;
  localparam int unsigned DL    = 5;
  localparam int unsigned FSW   = 11;
  localparam int unsigned FSM   = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned VW    = PW + 5;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          load_valid_i = 1'b0;
  logic          load_ready_o;
  logic [PW-1:0] load_pitch_i = '0;
  logic [DW-1:0] load_duration_i = '0;
  logic          load_last_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_en_i = 1'b0;
  logic [PW-1:0] pitch_o;
  logic          rest_o;
  logic          note_start_o;
  logic          playing_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  // Model of the table as the user sees it.
  int m_pitch [DEPTH];
  int m_dur   [DEPTH];
  int m_len = 0;
  int m_wr  = 0;

  note_sequencer #(
    .PITCH_BITWIDTH(PW), .DUR_BITWIDTH(DW), .DEPTH_LOG2(DL),
    .FS_BITWIDTH(FSW), .FS_MAXVAL(FSM)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .load_pitch_i(load_pitch_i), .load_duration_i(load_duration_i),
    .load_last_i(load_last_i), .start_i(start_i), .stop_i(stop_i),
    .loop_en_i(loop_en_i), .pitch_o(pitch_o), .rest_o(rest_o),
    .note_start_o(note_start_o), .playing_o(playing_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int note_len(input int i);
    return ((m_dur[i] == 0) ? 1 : m_dur[i]) * FSM;
  endfunction

  function automatic int total_len();
    int s;
    s = 0;
    for (int i = 0; i < m_len; i++) s += note_len(i);
    return s;
  endfunction

  // {pitch, rest, note_start, playing, done, load_ready}
  function automatic logic [VW-1:0] idle_vec(input bit d);
    return {PW'(0), 1'b1, 1'b0, 1'b0, d, 1'b1};
  endfunction

  // Expected outputs k cycles after the start edge, from the melody timeline.
  function automatic logic [VW-1:0] model_out(input int k, input bit loop, input int stop_at);
    int t;
    int tot;
    if (stop_at > 0 && k > stop_at) return idle_vec(1'b0);
    tot = total_len();
    t = k - 1;
    if (loop) t = t % tot;
    else if (t >= tot) return idle_vec(t == tot);
    for (int i = 0; i < m_len; i++) begin
      if (t < note_len(i))
        return {PW'(m_pitch[i]), 1'(m_pitch[i] == 0), 1'(t == 0), 1'b1, 1'b0, 1'b0};
      t -= note_len(i);
    end
    return idle_vec(1'b0);
  endfunction

  function automatic logic [VW-1:0] got_vec();
    return {pitch_o, rest_o, note_start_o, playing_o, done_o, load_ready_o};
  endfunction

  task automatic load_entry(input int p, input int d, input bit last);
    checks++;
    if (load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL load_ready before write: got %b exp 1", load_ready_o);
    end
    load_valid_i = 1'b1; load_pitch_i = PW'(p); load_duration_i = DW'(d); load_last_i = last;
    step();
    load_valid_i = 1'b0; load_last_i = 1'b0;
    m_pitch[m_wr] = p; m_dur[m_wr] = d;
    if (last || m_wr == DEPTH - 1) begin m_len = m_wr + 1; m_wr = 0; end
    else m_wr++;
  endtask

  task automatic run_play(input bit loop, input int stop_at, input int ncyc, input string name);
    logic [VW-1:0] exp_v;
    loop_en_i = loop; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      exp_v = model_out(k, loop, stop_at);
      checks++;
      if (got_vec() !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d got %h exp %h", name, k, got_vec(), exp_v);
      end
      stop_i = (k == stop_at);
      step();
    end
    stop_i = 1'b0; loop_en_i = 1'b0;
  endtask

  task automatic check_idle(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_vec() !== idle_vec(1'b0)) begin
        errors++;
        $display("FAIL %s cycle %0d got %h exp %h", name, k, got_vec(), idle_vec(1'b0));
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step(); step();
    check_idle(1, "reset_values");
    reset_i = 1'b0;
    check_idle(1, "after_reset");
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_idle(5, "start_empty");
  endtask

  task automatic test_oneshot();
    load_entry(177, 4, 1'b0);
    load_entry(0, 2, 1'b0);
    load_entry(266, 1, 1'b1);
    run_play(1'b0, 0, total_len() + 3, "oneshot");
  endtask

  task automatic test_loop_stop();
    run_play(1'b1, 35, 38, "loop_stop");
  endtask

  task automatic test_full_table();
    for (int i = 0; i < 33; i++) load_entry(int'($urandom_range(1, 511)), int'($urandom_range(0, 3)), 1'b0);
    run_play(1'b0, 0, total_len() + 3, "full_table");
  endtask

  task automatic test_dur_zero();
    load_entry(123, 0, 1'b0);
    load_entry(0, 0, 1'b0);
    load_entry(45, 0, 1'b1);
    run_play(1'b0, 0, total_len() + 3, "dur_zero");
  endtask

  task automatic test_load_during_play();
    loop_en_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid_i = 1'b1; load_last_i = 1'(i == 0);
      load_pitch_i = PW'($urandom_range(1, 511)); load_duration_i = DW'($urandom_range(0, 7));
      checks++;
      if (load_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_play cycle %0d got %b exp 0", i, load_ready_o);
      end
      step();
    end
    load_valid_i = 1'b0; load_last_i = 1'b0; stop_i = 1'b1;
    step();
    stop_i = 1'b0; loop_en_i = 1'b0;
    check_idle(2, "stop_after_loads");
    run_play(1'b0, 0, total_len() + 3, "replay_unchanged");
  endtask

  task automatic test_start_stop();
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    check_idle(4, "start_with_stop");
  endtask

  task automatic test_reset_mid();
    loop_en_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0; loop_en_i = 1'b0;
    m_len = 0; m_wr = 0;
    check_idle(2, "reset_mid_note");
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_idle(4, "start_after_reset");
  endtask

  task automatic test_random();
    int n;
    int p;
    int tot;
    int stop_at;
    bit loop;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        p = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 511));
        load_entry(p, int'($urandom_range(0, 4)), 1'(i == n - 1));
      end
      tot = total_len();
      loop = 1'($urandom_range(0, 1));
      if (loop) begin
        stop_at = int'($urandom_range(1, 2 * tot));
        run_play(1'b1, stop_at, stop_at + 3, "rand_loop");
      end else begin
        stop_at = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, tot));
        run_play(1'b0, stop_at, tot + 3, "rand_oneshot");
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop_stop();
    test_full_table();
    test_dur_zero();
    test_load_during_play();
    test_start_stop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
